// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
interface if_id_queue_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] instrF;
  logic [WIDTH-1:0] incPCF;
  logic             errF;
  logic             validF;
  logic             readyF;
  logic [WIDTH-1:0] instrD;
  logic [WIDTH-1:0] incPCD;
  logic             errD;
  logic             validD;
  logic             stallD;
  logic             flush;
  logic             halted;
  logic [1:0]       count;

  modport master (
    output instrF, incPCF, errF, validF, stallD, flush,
    input  readyF, instrD, incPCD, errD, validD, halted, count
  );

  modport slave (
    input  instrF, incPCF, errF, validF, stallD, flush,
    output readyF, instrD, incPCD, errD, validD, halted, count
  );
endinterface

// File: rtl/if_id_queue.sv
// Two-entry circular IF/ID buffer: absorbs decode stalls, drops on flush,
// feeds NOPs when empty and blocks fetch once a HALT has been issued.
module if_id_queue #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR  = 16'h0800,
  parameter logic [WIDTH-1:0] HALT_INSTR = 16'h0000
) (
  input logic        clk,
  input logic        rst,
  if_id_queue_if.slave q
);
  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
    logic             err;
  } entry_t;

  entry_t     mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] cnt;
  logic       halted_q;
  logic       push, pop, head_vld;
  entry_t     head;

  // All outputs come from registered state only, so async reset shows at once.
  assign head_vld = (cnt != 2'd0);
  assign head     = mem[rd_ptr];
  assign q.readyF = (cnt != 2'd2) & ~halted_q;
  assign q.validD = head_vld;
  assign q.instrD = head_vld ? head.instr : NOP_INSTR;
  assign q.incPCD = head_vld ? head.pc    : '0;
  assign q.errD   = head_vld ? head.err   : 1'b0;
  assign q.halted = halted_q;
  assign q.count  = cnt;

  assign push = q.validF & q.readyF;
  assign pop  = head_vld & ~q.stallD & ~q.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      halted_q <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else if (q.flush) begin
      cnt      <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{instr: q.instrF, pc: q.incPCF, err: q.errF};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (head.instr == HALT_INSTR) halted_q <= 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: inputs driven and outputs sampled on negedge.
module tb_if_id_queue;
  logic clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;

  if_id_queue_if #(.WIDTH(16)) bus ();

  if_id_queue #(.WIDTH(16), .NOP_INSTR(16'h0800), .HALT_INSTR(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc, input logic e);
    bus.validF = v;
    bus.instrF = ins;
    bus.incPCF = pc;
    bus.errF   = e;
  endtask

  initial begin
    rst = 1'b1;
    bus.stallD = 1'b0;
    bus.flush  = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    check("rst_validD", bus.validD, 0);
    check("rst_instrD", bus.instrD, 16'h0800);
    check("rst_incPCD", bus.incPCD, 0);
    check("rst_errD",   bus.errD, 0);
    check("rst_readyF", bus.readyF, 1);
    check("rst_count",  bus.count, 0);
    check("rst_halted", bus.halted, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single push, no stall: visible the next cycle, then drains.
    drive(1'b1, 16'h4001, 16'h0002, 1'b0);
    tick();
    check("t1_instrD", bus.instrD, 16'h4001);
    check("t1_incPCD", bus.incPCD, 16'h0002);
    check("t1_validD", bus.validD, 1);
    check("t1_count",  bus.count, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    check("t1_empty_validD", bus.validD, 0);
    check("t1_empty_instrD", bus.instrD, 16'h0800);

    // Stall fills the queue; third push refused.
    bus.stallD = 1'b1;
    drive(1'b1, 16'h1111, 16'h0010, 1'b0);
    tick();
    check("t2_count1", bus.count, 1);
    drive(1'b1, 16'h2222, 16'h0012, 1'b1);
    tick();
    check("t2_count2", bus.count, 2);
    check("t2_readyF_full", bus.readyF, 0);
    drive(1'b1, 16'h3333, 16'h0014, 1'b0);
    tick();
    check("t2_count_hold", bus.count, 2);
    check("t2_head_A", bus.instrD, 16'h1111);
    check("t2_errD_A", bus.errD, 0);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    bus.stallD = 1'b0;
    tick();
    check("t2_head_B", bus.instrD, 16'h2222);
    check("t2_pc_B", bus.incPCD, 16'h0012);
    check("t2_errD_B", bus.errD, 1);
    check("t2_readyF_after_pop", bus.readyF, 1);
    check("t2_count_after_pop", bus.count, 1);
    tick();
    check("t2_no_C_validD", bus.validD, 0);
    check("t2_no_C_count", bus.count, 0);

    // Simultaneous push/pop keeps count at 1 through pointer wraps.
    drive(1'b1, 16'h5000, 16'h0020, 1'b0);
    tick();
    check("t3_head0", bus.instrD, 16'h5000);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'h5001 + 16'(i), 16'h0022 + 16'(2 * i), 1'b0);
      tick();
      check("t3_count", bus.count, 1);
      check("t3_instrD", bus.instrD, 16'h5001 + 16'(i));
      check("t3_incPCD", bus.incPCD, 16'h0022 + 16'(2 * i));
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    check("t3_drained", bus.count, 0);

    // Flush on a full, stalled queue drops everything including fetch's push.
    bus.stallD = 1'b1;
    drive(1'b1, 16'h6001, 16'h0030, 1'b0);
    tick();
    drive(1'b1, 16'h6002, 16'h0032, 1'b0);
    tick();
    check("t4_full", bus.count, 2);
    bus.flush = 1'b1;
    drive(1'b1, 16'h6003, 16'h0034, 1'b0);
    tick();
    check("t4_count", bus.count, 0);
    check("t4_validD", bus.validD, 0);
    check("t4_instrD", bus.instrD, 16'h0800);
    bus.flush  = 1'b0;
    bus.stallD = 1'b0;
    drive(1'b1, 16'h6004, 16'h0036, 1'b0);
    tick();
    check("t4_repush", bus.instrD, 16'h6004);
    check("t4_repush_count", bus.count, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    tick();

    // HALT queued does not block; HALT popped does; X still drains.
    bus.stallD = 1'b1;
    drive(1'b1, 16'h0000, 16'h0040, 1'b0);
    tick();
    check("t5_queued_halt_readyF", bus.readyF, 1);
    check("t5_queued_halted", bus.halted, 0);
    drive(1'b1, 16'h4002, 16'h0042, 1'b0);
    tick();
    check("t5_full", bus.count, 2);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    bus.stallD = 1'b0;
    tick();
    check("t5_halted", bus.halted, 1);
    check("t5_X_head", bus.instrD, 16'h4002);
    check("t5_readyF_halted", bus.readyF, 0);
    drive(1'b1, 16'h7777, 16'h0044, 1'b0);
    tick();
    check("t5_drained", bus.count, 0);
    check("t5_still_halted", bus.halted, 1);
    check("t5_blocked", bus.validD, 0);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("t5_flush_halted", bus.halted, 0);
    check("t5_flush_readyF", bus.readyF, 1);

    // HALT pop coinciding with flush: flush wins.
    drive(1'b1, 16'h0000, 16'h0050, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("t5b_halted", bus.halted, 0);
    check("t5b_count", bus.count, 0);

    // Async reset mid-cycle on a full queue.
    bus.stallD = 1'b1;
    drive(1'b1, 16'h8001, 16'h0060, 1'b0);
    tick();
    drive(1'b1, 16'h8002, 16'h0062, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    check("t6_full", bus.count, 2);
    #2 rst = 1'b1;
    #1;
    check("t6_validD", bus.validD, 0);
    check("t6_count", bus.count, 0);
    check("t6_readyF", bus.readyF, 1);
    check("t6_instrD", bus.instrD, 16'h0800);
    @(negedge clk);
    rst = 1'b0;
    bus.stallD = 1'b0;
    tick();
    check("t6_post_empty", bus.validD, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
